p_decode_ctrl_1_n: RTL
======================

P_DECODE_CTRL_1_N -- requirements
Module: p_decode_ctrl_1_n

Interface
REQ-001 Parameter N_DST, 4, destination count; power of 2, range 2..8.
REQ-002 Parameter CTRL_W, 4, k_ctrl width; CTRL_W >= log2(N_DST).
REQ-003 Parameter MCAST, 0, 0 = range decode of k_ctrl, 1 = multicast using dst_mask.
REQ-004 Parameter TIMEOUT, 255, wait-cycle limit for err_timeout; 1..65535.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 t_kp_req  in  1  upstream request; held until t_kp_ack.
REQ-008 t_kp_ack  out  1  upstream ack; combinational; one-cycle handshake completion.
REQ-009 k_ctrl  in  CTRL_W  destination selector (MCAST=0).
REQ-010 dst_mask  in  N_DST  destination set, bit i = destination i (MCAST=1).
REQ-011 i_p_req  out  N_DST  per-destination request.
REQ-012 i_p_ack  in  N_DST  per-destination ack; bit i only meaningful while i_p_req[i] is high.
REQ-013 err_clr  in  1  synchronous clear of err_timeout.
REQ-014 err_timeout  out  1  sticky timeout flag.
REQ-015 txn_cnt  out  16  count of completed transactions.

Function
REQ-016 MCAST=0: sel_live = one-hot of k_ctrl[CTRL_W-1 -: log2(N_DST)]; with N_DST=2, CTRL_W=4: k_ctrl<8 -> dest 0, k_ctrl>=8 -> dest 1.
REQ-017 MCAST=1: sel_live = dst_mask.
REQ-018 Register active is clear when idle; sel_eff = sel_live while active=0, and sel_eff = sel_q while active=1.
REQ-019 On a rising edge with t_kp_req=1, active=0 and t_kp_ack=0: sel_q <= sel_live and active <= 1; later k_ctrl/dst_mask changes are ignored until completion.
REQ-020 i_p_req[i] = t_kp_req & sel_eff[i] & ~done[i]; zero-cycle latency from t_kp_req.
REQ-021 done[i] sets on an edge where i_p_req[i] & i_p_ack[i] = 1; a set done[i] drops i_p_req[i] the next cycle, and the destination is not re-requested in the same transaction.
REQ-022 t_kp_ack = t_kp_req & AND over i of (i_p_ack[i] | ~i_p_req[i]); it is high in the cycle the last outstanding ack arrives, and acks for different destinations may arrive in any cycles, including simultaneously.
REQ-023 On an edge with t_kp_ack=1: active <= 0, done <= 0, txn_cnt <= txn_cnt+1 (wraps 0xFFFF -> 0).
REQ-024 Empty selection (dst_mask=0): t_kp_ack = t_kp_req in the same cycle, no i_p_req asserted, and txn_cnt increments.
REQ-025 Back-to-back: a new t_kp_req the cycle after an ack decodes sel_live afresh.
REQ-026 t_kp_req dropped before ack (abandon): on that edge active <= 0, done <= 0, and txn_cnt is unchanged.
REQ-027 wait_cnt (16 bit) increments each edge with t_kp_req=1 & t_kp_ack=0, saturates at TIMEOUT, and clears on ack or when t_kp_req=0.
REQ-028 err_timeout sets on the edge where wait_cnt reaches TIMEOUT, stays set across transactions, and clears on an edge with err_clr=1 unless a set condition occurs on the same edge (set wins). The handshake is not aborted.

Reset
REQ-029 reset_n=0 asynchronously clears active, sel_q, done, wait_cnt, err_timeout and txn_cnt; i_p_req=0 and t_kp_ack=0 while reset_n=0.
REQ-030 A reset mid-transaction discards partial acks; after release, a still-high t_kp_req starts a new transaction and re-requests all selected destinations.

Structure
REQ-031 Package p_decode_pkg holds TXN_CNT_W=16, WAIT_CNT_W=16 and the MCAST mode constants.
REQ-032 Sub-module p_decode_sel (combinational k_ctrl/dst_mask -> sel_live) is instantiated once.

Verification (N_DST=4, CTRL_W=4 unless stated)
REQ-033 k_ctrl=0x9, i_p_ack[2]=1 after 3 cycles -> i_p_req=0100 immediately, t_kp_ack in the ack cycle, txn_cnt=1.
REQ-034 MCAST=1, dst_mask=1011, acks at cycles 1, 4, 2 for dests 0, 1, 3; dst_mask changed at cycle 2 -> each req drops after its ack, t_kp_ack only at cycle 4, dest 2 never requested.
REQ-035 MCAST=1, dst_mask=0000 -> t_kp_ack=1 in the same cycle as t_kp_req, txn_cnt increments.
REQ-036 TIMEOUT=5, no acks -> err_timeout=1 after 5 waiting edges; err_clr pulse -> 0; ack then completes normally.
REQ-037 reset_n low mid-transaction after dest 0 acked (mask 0011) -> outputs 0 at once; after release, i_p_req=0011 again.
REQ-038 N_DST=2, k_ctrl sweep 0..15 -> dest 0 for 0..7, dest 1 for 8..15.

Source files
------------

// File: rtl/p_decode_pkg.sv
// rtl/p_decode_pkg.sv - shared widths and decode-mode constants for the 1:N request splitter
package p_decode_pkg;

    localparam int TXN_CNT_W  = 16;
    localparam int WAIT_CNT_W = 16;

    localparam int MCAST_RANGE = 0;
    localparam int MCAST_MASK  = 1;

    function automatic int sel_idx_w(input int n_dst);
        return (n_dst > 1) ? $clog2(n_dst) : 1;
    endfunction

endpackage

// File: rtl/p_decode_sel.sv
// rtl/p_decode_sel.sv - destination selector: range decode of k_ctrl or pass-through of dst_mask
module p_decode_sel
    import p_decode_pkg::*;
#(
    parameter int N_DST  = 4,
    parameter int CTRL_W = 4,
    parameter int MCAST  = MCAST_RANGE
) (
    input  logic [CTRL_W-1:0] k_ctrl,
    input  logic [N_DST-1:0]  dst_mask,
    output logic [N_DST-1:0]  sel_live
);

    localparam int IDX_W = sel_idx_w(N_DST);

    logic [IDX_W-1:0] dst_idx;
    logic             unused_inputs;

    // Top bits of k_ctrl split its range into N_DST equal slices.
    assign dst_idx       = k_ctrl[CTRL_W-1 -: IDX_W];
    assign unused_inputs = ^{k_ctrl, dst_mask};

    always_comb begin
        sel_live = '0;
        if (MCAST == MCAST_MASK) begin
            sel_live = dst_mask;
        end else begin
            sel_live[dst_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/p_decode_ctrl_1_n.sv
// rtl/p_decode_ctrl_1_n.sv - fans one upstream request out to N destinations and joins their acks
module p_decode_ctrl_1_n
    import p_decode_pkg::*;
#(
    parameter int N_DST   = 4,
    parameter int CTRL_W  = 4,
    parameter int MCAST   = 0,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 t_kp_req,
    output logic                 t_kp_ack,
    input  logic [CTRL_W-1:0]    k_ctrl,
    input  logic [N_DST-1:0]     dst_mask,
    output logic [N_DST-1:0]     i_p_req,
    input  logic [N_DST-1:0]     i_p_ack,
    input  logic                 err_clr,
    output logic                 err_timeout,
    output logic [TXN_CNT_W-1:0] txn_cnt
);

    logic [N_DST-1:0]      sel_live;
    logic [N_DST-1:0]      sel_q;
    logic [N_DST-1:0]      sel_eff;
    logic [N_DST-1:0]      done;
    logic                  active;
    logic [WAIT_CNT_W-1:0] wait_cnt;
    logic                  waiting;
    logic                  hit_timeout;

    p_decode_sel #(
        .N_DST  (N_DST),
        .CTRL_W (CTRL_W),
        .MCAST  (MCAST)
    ) u_sel (
        .k_ctrl   (k_ctrl),
        .dst_mask (dst_mask),
        .sel_live (sel_live)
    );

    // Selection is frozen once the transaction has been seen on a clock edge.
    assign sel_eff  = active ? sel_q : sel_live;
    assign i_p_req  = {N_DST{t_kp_req & reset_n}} & sel_eff & ~done;
    assign t_kp_ack = t_kp_req & reset_n & (&(i_p_ack | ~i_p_req));

    assign waiting     = t_kp_req & ~t_kp_ack;
    assign hit_timeout = waiting && (wait_cnt == WAIT_CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active <= 1'b0;
            sel_q  <= '0;
            done   <= '0;
        end else if (!t_kp_req || t_kp_ack) begin
            // Completion or abandon both end the transaction.
            active <= 1'b0;
            done   <= '0;
        end else begin
            if (!active) begin
                active <= 1'b1;
                sel_q  <= sel_live;
            end
            done <= done | (i_p_req & i_p_ack);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            txn_cnt <= '0;
        end else if (t_kp_ack) begin
            txn_cnt <= txn_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= '0;
        end else if (!waiting) begin
            wait_cnt <= '0;
        end else if (wait_cnt != WAIT_CNT_W'(TIMEOUT)) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Set only on the edge the limit is reached, so a clear sticks while still saturated.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_timeout <= 1'b0;
        end else if (hit_timeout) begin
            err_timeout <= 1'b1;
        end else if (err_clr) begin
            err_timeout <= 1'b0;
        end
    end

endmodule
